// File: rtl/fracn_divider_ctrl.sv
// rtl/fracn_divider_ctrl.sv - fractional-N ratio sequencer for the PLL feedback divider
module fracn_divider_ctrl #(
    parameter int INT_WIDTH  = 8,
    parameter int FRAC_WIDTH = 16,
    parameter int MIN_RATIO  = 2
) (
    input  logic                  input_clk_digital,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic [INT_WIDTH-1:0]  cfg_int,
    input  logic [FRAC_WIDTH-1:0] cfg_frac,
    output logic                  cfg_err,
    input  logic                  div_wrap,
    output logic [INT_WIDTH:0]    div_ratio,
    output logic                  div_load,
    output logic                  active
);

    typedef enum logic [1:0] {IDLE, RUN, PENDING} state_t;

    state_t                state;
    state_t                state_nxt;
    logic                  loaded;
    logic [INT_WIDTH-1:0]  act_int;
    logic [FRAC_WIDTH-1:0] act_frac;
    logic [INT_WIDTH-1:0]  pend_int;
    logic [FRAC_WIDTH-1:0] pend_frac;
    logic [FRAC_WIDTH-1:0] acc;
    logic [FRAC_WIDTH:0]   sum;
    logic                  xfer;
    logic                  cfg_good;
    logic                  cfg_bad;

    assign xfer     = cfg_valid && cfg_ready;
    assign cfg_good = xfer && (cfg_int >= INT_WIDTH'(MIN_RATIO));
    assign cfg_bad  = xfer && (cfg_int <  INT_WIDTH'(MIN_RATIO));
    assign sum      = {1'b0, acc} + {1'b0, act_frac};

    always_ff @(posedge input_clk_digital) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (enable && (loaded || cfg_good)) state_nxt = RUN;
            RUN:     if (!enable) state_nxt = IDLE;
                     else if (cfg_good) state_nxt = PENDING;
            PENDING: if (!enable) state_nxt = IDLE;
                     else if (div_wrap) state_nxt = RUN;
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake outputs are registered from the next state so they line up with it.
    always_ff @(posedge input_clk_digital) begin
        if (reset) begin
            loaded    <= 1'b0;
            acc       <= '0;
            act_int   <= '0;
            act_frac  <= '0;
            pend_int  <= '0;
            pend_frac <= '0;
            div_ratio <= (INT_WIDTH+1)'(MIN_RATIO);
            div_load  <= 1'b0;
            cfg_err   <= 1'b0;
            cfg_ready <= 1'b0;
            active    <= 1'b0;
        end else begin
            div_load  <= 1'b0;
            cfg_err   <= cfg_bad;
            cfg_ready <= (state_nxt != PENDING);
            active    <= (state_nxt != IDLE);
            case (state)
                IDLE: begin
                    if (cfg_good) begin
                        act_int  <= cfg_int;
                        act_frac <= cfg_frac;
                        loaded   <= 1'b1;
                    end
                    if (state_nxt == RUN) begin
                        div_ratio <= {1'b0, cfg_good ? cfg_int : act_int};
                        acc       <= '0;
                        div_load  <= 1'b1;
                    end
                end
                RUN: begin
                    if (!enable) begin
                        acc <= '0;
                        if (cfg_good) begin
                            act_int  <= cfg_int;
                            act_frac <= cfg_frac;
                        end
                    end else begin
                        if (div_wrap) begin
                            acc       <= sum[FRAC_WIDTH-1:0];
                            div_ratio <= {1'b0, act_int} + (INT_WIDTH+1)'(sum[FRAC_WIDTH]);
                        end
                        if (cfg_good) begin
                            pend_int  <= cfg_int;
                            pend_frac <= cfg_frac;
                        end
                    end
                end
                PENDING: begin
                    if (!enable || div_wrap) begin
                        act_int  <= pend_int;
                        act_frac <= pend_frac;
                        acc      <= '0;
                        if (enable) begin
                            div_ratio <= {1'b0, pend_int};
                            div_load  <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
